// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU controller: scoreboard entry state and
// the ID->controller and controller->EX side-band bundles.
package fir_xifu_pkg;

  localparam int X_ID_WIDTH_DEFAULT = 4;

  // Life cycle of one tracked XIF instruction id
  typedef enum logic [1:0] {
    SB_FREE      = 2'b00,
    SB_ISSUED    = 2'b01,
    SB_COMMITTED = 2'b10
  } sb_state_t;

  // Issue notification from the ID stage
  typedef struct packed {
    logic                          issue;
    logic [X_ID_WIDTH_DEFAULT-1:0] id;
  } id2ctrl_t;

  // Side-effect permission and flush towards the EX stage
  typedef struct packed {
    logic commit;
    logic kill;
  } ctrl2ex_t;

endpackage

// File: rtl/fir_xifu_ctrl_if.sv
// Bundle of all pipeline-facing controller signals. The controller is the
// slave; the pipeline (or a bench) is the master.
interface fir_xifu_ctrl_if #(
  parameter int X_ID_WIDTH = fir_xifu_pkg::X_ID_WIDTH_DEFAULT
);

  logic                  clear_i;
  logic                  issue_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic                  commit_valid_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic                  commit_kill_i;
  logic                  ex_valid_i;
  logic [X_ID_WIDTH-1:0] ex_id_i;
  logic                  ex_commit_o;
  logic                  retire_i;
  logic [X_ID_WIDTH-1:0] retire_id_i;
  logic                  ready_o;
  logic                  kill_o;
  logic [X_ID_WIDTH:0]   outstanding_o;
  logic                  err_o;

  modport slave (
    input  clear_i, issue_i, issue_id_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  ex_valid_i, ex_id_i,
    input  retire_i, retire_id_i,
    output ex_commit_o, ready_o, kill_o, outstanding_o, err_o
  );

  modport master (
    output clear_i, issue_i, issue_id_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output ex_valid_i, ex_id_i,
    output retire_i, retire_id_i,
    input  ex_commit_o, ready_o, kill_o, outstanding_o, err_o
  );

endinterface

// File: rtl/fir_xifu_sb_entry.sv
// One scoreboard entry. Events of a single cycle are applied in the order
// retire -> issue -> commit, so an id can be retired and re-issued in the
// same cycle, and an issue plus commit of the same id resolves directly.
module fir_xifu_sb_entry
  import fir_xifu_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      clear_i,
  input  logic      issue_hit_i,
  input  logic      commit_hit_i,
  input  logic      kill_i,
  input  logic      retire_hit_i,
  output sb_state_t state_o,
  output logic      err_o,
  output logic      eff_kill_o,
  output logic      retire_ok_o
);

  sb_state_t r_state;
  sb_state_t w_state_next;
  sb_state_t w_after_retire;
  sb_state_t w_after_issue;

  // Entry state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SB_FREE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and per-entry event decode
  always_comb begin
    w_after_retire = r_state;
    w_after_issue  = r_state;
    w_state_next   = r_state;
    err_o          = 1'b0;
    eff_kill_o     = 1'b0;
    retire_ok_o    = 1'b0;

    // Only a committed instruction may leave through WB
    if (retire_hit_i) begin
      if (r_state == SB_COMMITTED) begin
        w_after_retire = SB_FREE;
        retire_ok_o    = 1'b1;
      end else begin
        err_o = 1'b1;
      end
    end

    // Issue always wins the entry; reusing a live id is flagged
    w_after_issue = w_after_retire;
    if (issue_hit_i) begin
      if (w_after_retire != SB_FREE) begin
        err_o = 1'b1;
      end
      w_after_issue = SB_ISSUED;
    end

    // Commit/kill only acts on an issued entry
    w_state_next = w_after_issue;
    if (commit_hit_i) begin
      if (w_after_issue == SB_ISSUED) begin
        if (kill_i) begin
          w_state_next = SB_FREE;
          eff_kill_o   = 1'b1;
        end else begin
          w_state_next = SB_COMMITTED;
        end
      end else begin
        err_o = 1'b1;
      end
    end

    // Flush discards everything that happened this cycle
    if (clear_i) begin
      w_state_next = SB_FREE;
      err_o        = 1'b0;
      eff_kill_o   = 1'b0;
      retire_ok_o  = 1'b0;
    end
  end

  assign state_o = r_state;

endmodule

// File: rtl/fir_xifu_ctrl.sv
// FIR XIFU controller: per-id commit scoreboard, side-effect gating for EX,
// outstanding counter with ID back-pressure, kill pulse and sticky error.
// MAX_OUTSTANDING is expected in 1..2**X_ID_WIDTH.
module fir_xifu_ctrl
  import fir_xifu_pkg::*;
#(
  parameter int X_ID_WIDTH      = X_ID_WIDTH_DEFAULT,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic           clk_i,
  input logic           rst_ni,
  fir_xifu_ctrl_if.slave bus
);

  localparam int NUM_ENTRIES = 2 ** X_ID_WIDTH;
  localparam int CW          = X_ID_WIDTH + 1;
  localparam int SW          = X_ID_WIDTH + 3;

  sb_state_t              w_state [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_err_vec;
  logic [NUM_ENTRIES-1:0] w_kill_vec;
  logic [NUM_ENTRIES-1:0] w_retire_vec;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [SW-1:0] w_cnt_sum;
  logic          w_sat_err;
  logic          w_any_kill;
  logic          w_any_retire;
  logic          w_any_err;
  logic          r_kill;
  logic          r_err;
  ctrl2ex_t      w_ctrl2ex;

  // One FSM per id; hits are decoded from the shared id buses
  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      fir_xifu_sb_entry u_entry (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (bus.clear_i),
        .issue_hit_i  (bus.issue_i && (int'(bus.issue_id_i) == gi)),
        .commit_hit_i (bus.commit_valid_i && (int'(bus.commit_id_i) == gi)),
        .kill_i       (bus.commit_kill_i),
        .retire_hit_i (bus.retire_i && (int'(bus.retire_id_i) == gi)),
        .state_o      (w_state[gi]),
        .err_o        (w_err_vec[gi]),
        .eff_kill_o   (w_kill_vec[gi]),
        .retire_ok_o  (w_retire_vec[gi])
      );
    end
  endgenerate

  assign w_any_kill   = |w_kill_vec;
  assign w_any_retire = |w_retire_vec;
  assign w_any_err    = |w_err_vec;

  // Outstanding counter: net of issue, retire and effective kill, saturating
  always_comb begin
    w_cnt_sum  = {2'b00, r_cnt} + SW'(bus.issue_i) - SW'(w_any_retire) - SW'(w_any_kill);
    w_cnt_next = w_cnt_sum[CW-1:0];
    w_sat_err  = 1'b0;
    if (w_cnt_sum[SW-1]) begin
      w_cnt_next = '0;
      w_sat_err  = 1'b1;
    end else if (w_cnt_sum > SW'(NUM_ENTRIES)) begin
      w_cnt_next = CW'(NUM_ENTRIES);
      w_sat_err  = 1'b1;
    end
    if (bus.clear_i) begin
      w_cnt_next = '0;
      w_sat_err  = 1'b0;
    end
  end

  // Counter, kill pulse and sticky error registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_kill <= 1'b0;
      r_err  <= 1'b0;
    end else if (bus.clear_i) begin
      r_cnt  <= '0;
      r_kill <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_kill <= w_any_kill;
      r_err  <= r_err | w_any_err | w_sat_err;
    end
  end

  // EX may proceed only once its id is committed; combinational so EX can stall on it
  assign w_ctrl2ex.commit = bus.ex_valid_i && (w_state[bus.ex_id_i] == SB_COMMITTED);
  assign w_ctrl2ex.kill   = r_kill;

  assign bus.ex_commit_o   = w_ctrl2ex.commit;
  assign bus.kill_o        = w_ctrl2ex.kill;
  assign bus.ready_o       = (r_cnt < CW'(MAX_OUTSTANDING));
  assign bus.outstanding_o = r_cnt;
  assign bus.err_o         = r_err;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Bench for fir_xifu_ctrl: table of per-cycle stimulus with expected outputs
// pushed to a scoreboard queue and checked at the falling edge, plus a
// hand-written asynchronous-reset sequence.
module tb_fir_xifu_ctrl;

  typedef struct {
    logic       iss;
    logic [3:0] iid;
    logic       cv;
    logic [3:0] cid;
    logic       ck;
    logic       exv;
    logic [3:0] exid;
    logic       ret;
    logic [3:0] rid;
    logic       clr;
    logic       e_ec;
    logic       e_rdy;
    logic       e_kill;
    logic [4:0] e_cnt;
    logic       e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   mon_idx = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  fir_xifu_ctrl_if #(.X_ID_WIDTH(4)) bus ();

  fir_xifu_ctrl #(.X_ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic iss, input int iid, input logic cv, input int cid,
                             input logic ck, input logic exv, input int exid, input logic ret,
                             input int rid, input logic clr, input logic ec, input logic rdy,
                             input logic k, input int cnt, input logic err);
    vec_t r;
    r.iss = iss; r.iid = 4'(iid); r.cv = cv; r.cid = 4'(cid); r.ck = ck;
    r.exv = exv; r.exid = 4'(exid); r.ret = ret; r.rid = 4'(rid); r.clr = clr;
    r.e_ec = ec; r.e_rdy = rdy; r.e_kill = k; r.e_cnt = 5'(cnt); r.e_err = err;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.issue_i        = x.iss;
    bus.issue_id_i     = x.iid;
    bus.commit_valid_i = x.cv;
    bus.commit_id_i    = x.cid;
    bus.commit_kill_i  = x.ck;
    bus.ex_valid_i     = x.exv;
    bus.ex_id_i        = x.exid;
    bus.retire_i       = x.ret;
    bus.retire_id_i    = x.rid;
    bus.clear_i        = x.clr;
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    chk({tag, ".ex_commit"}, int'(bus.ex_commit_o), int'(e.e_ec));
    chk({tag, ".ready"}, int'(bus.ready_o), int'(e.e_rdy));
    chk({tag, ".kill"}, int'(bus.kill_o), int'(e.e_kill));
    chk({tag, ".outstanding"}, int'(bus.outstanding_o), int'(e.e_cnt));
    chk({tag, ".err"}, int'(bus.err_o), int'(e.e_err));
  endtask

  // Scoreboard monitor: compares the oldest pending expectation mid-cycle
  always @(negedge clk) begin
    vec_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_outputs($sformatf("v%0d", mon_idx), e);
      $display("txn %0d: iss=%0d/%0d cv=%0d/%0d k=%0d ret=%0d/%0d clr=%0d -> ec=%0d rdy=%0d kill=%0d cnt=%0d err=%0d",
               mon_idx, e.iss, e.iid, e.cv, e.cid, e.ck, e.ret, e.rid, e.clr,
               bus.ex_commit_o, bus.ready_o, bus.kill_o, bus.outstanding_o, bus.err_o);
      mon_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idle;
    idle = v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0);

    //      iss id  cv id k  exv id ret id clr  ec rdy k cnt err
    // issue/commit/retire of id 3 with EX waiting on it
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    tbl.push_back(v(1,3, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    tbl.push_back(v(0,0, 1,3,0, 1,3, 0,0, 0, 0,1,0,1,0));
    tbl.push_back(v(0,0, 0,0,0, 1,3, 0,0, 0, 1,1,0,1,0));
    tbl.push_back(v(0,0, 0,0,0, 1,3, 1,3, 0, 1,1,0,1,0));
    tbl.push_back(v(0,0, 0,0,0, 1,3, 0,0, 0, 0,1,0,0,0));
    // fill to MAX_OUTSTANDING, back-pressure, retire releases next cycle
    tbl.push_back(v(1,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    tbl.push_back(v(1,1, 0,0,0, 0,0, 0,0, 0, 0,1,0,1,0));
    tbl.push_back(v(1,2, 0,0,0, 0,0, 0,0, 0, 0,1,0,2,0));
    tbl.push_back(v(1,3, 1,0,0, 0,0, 0,0, 0, 0,1,0,3,0));
    tbl.push_back(v(0,0, 0,0,0, 1,0, 0,0, 0, 1,0,0,4,0));
    tbl.push_back(v(0,0, 0,0,0, 1,0, 1,0, 0, 1,0,0,4,0));
    tbl.push_back(v(0,0, 0,0,0, 1,0, 0,0, 0, 0,1,0,3,0));
    tbl.push_back(v(0,0, 1,1,0, 0,0, 0,0, 0, 0,1,0,3,0));
    tbl.push_back(v(0,0, 1,2,0, 0,0, 1,1, 0, 0,1,0,3,0));
    tbl.push_back(v(0,0, 1,3,0, 0,0, 1,2, 0, 0,1,0,2,0));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 1,3, 0, 0,1,0,1,0));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    // same-cycle issue + kill of id 5
    tbl.push_back(v(1,5, 1,5,1, 1,5, 0,0, 0, 0,1,0,0,0));
    tbl.push_back(v(0,0, 0,0,0, 1,5, 0,0, 0, 0,1,1,0,0));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    // issue id 2 while retiring committed id 1
    tbl.push_back(v(1,1, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    tbl.push_back(v(0,0, 1,1,0, 0,0, 0,0, 0, 0,1,0,1,0));
    tbl.push_back(v(1,2, 0,0,0, 1,1, 1,1, 0, 1,1,0,1,0));
    tbl.push_back(v(0,0, 0,0,0, 1,2, 0,0, 0, 0,1,0,1,0));
    tbl.push_back(v(0,0, 1,2,0, 1,1, 0,0, 0, 0,1,0,1,0));
    tbl.push_back(v(0,0, 0,0,0, 1,2, 1,2, 0, 1,1,0,1,0));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    // retire of a FREE entry: sticky error, then clear
    tbl.push_back(v(0,0, 0,0,0, 0,0, 1,7, 0, 0,1,0,0,0));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,1));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,1));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 1, 0,1,0,0,1));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    // kill of a FREE entry: error, no pulse
    tbl.push_back(v(0,0, 1,9,1, 0,0, 0,0, 0, 0,1,0,0,0));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,1));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 1, 0,1,0,0,1));
    // kill of an ISSUED entry in a later cycle
    tbl.push_back(v(1,6, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    tbl.push_back(v(0,0, 1,6,1, 0,0, 0,0, 0, 0,1,0,1,0));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,1,0,0));
    tbl.push_back(v(0,0, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));

    drive(idle);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(posedge clk); #1;
    end

    // asynchronous reset with a pending kill and a committed entry
    drive(v(1,1, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0)); exp_q.push_back(v(1,1, 0,0,0, 0,0, 0,0, 0, 0,1,0,0,0));
    @(posedge clk); #1;
    drive(v(1,2, 0,0,0, 0,0, 0,0, 0, 0,1,0,1,0)); exp_q.push_back(v(1,2, 0,0,0, 0,0, 0,0, 0, 0,1,0,1,0));
    @(posedge clk); #1;
    drive(v(0,0, 1,1,0, 0,0, 0,0, 0, 0,1,0,2,0)); exp_q.push_back(v(0,0, 1,1,0, 0,0, 0,0, 0, 0,1,0,2,0));
    @(posedge clk); #1;
    drive(v(0,0, 1,2,1, 1,1, 0,0, 0, 0,0,0,0,0));
    #3;
    chk("pre_rst.ex_commit", int'(bus.ex_commit_o), 1);
    chk("pre_rst.outstanding", int'(bus.outstanding_o), 2);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("in_rst", v(0,0, 0,0,0, 1,1, 0,0, 0, 0,1,0,0,0));
    drive(v(0,0, 0,0,0, 1,1, 0,0, 0, 0,1,0,0,0));
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(v(0,0, 0,0,0, 1,1, 0,0, 0, 0,1,0,0,0));
      exp_q.push_back(v(0,0, 0,0,0, 1,1, 0,0, 0, 0,1,0,0,0));
      @(posedge clk); #1;
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_xifu_ctrl.md
Name: fir_xifu_ctrl

Overview:
Controller and commit scoreboard for the FIR XIFU pipeline (ID -> EX -> WB).
- Tracks every instruction accepted by the ID stage, keyed by its XIF instruction id.
- Applies the core's XIF commit/kill decisions to the tracked instructions.
- Gates EX-stage side effects (memory requests, register-file writes) until the instruction is committed.
- Frees entries on WB retire and back-pressures ID when too many instructions are outstanding.

Parameters:
X_ID_WIDTH, 4, width of XIF instruction id; scoreboard holds 2**X_ID_WIDTH entries indexed by id.
MAX_OUTSTANDING, 4, maximum non-FREE entries before ready_o deasserts (1..2**X_ID_WIDTH).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous flush of all controller state
issue_i  in  1  ID accepted an instruction this cycle (id2ctrl.issue)
issue_id_i  in  X_ID_WIDTH  id of issued instruction (id2ctrl.id)
commit_valid_i  in  1  XIF commit transaction valid
commit_id_i  in  X_ID_WIDTH  XIF commit id
commit_kill_i  in  1  XIF commit kill flag
ex_valid_i  in  1  EX stage holds a valid instruction
ex_id_i  in  X_ID_WIDTH  id of instruction in EX
ex_commit_o  out  1  EX instruction committed; side effects allowed
retire_i  in  1  WB retires an instruction this cycle
retire_id_i  in  X_ID_WIDTH  id of retiring instruction
ready_o  out  1  ID may accept a new instruction
kill_o  out  1  one-cycle flush pulse to ID/EX pipe registers
outstanding_o  out  X_ID_WIDTH+1  number of non-FREE entries
err_o  out  1  sticky protocol-violation flag

Behaviour:
- Per-entry state (sb_state_t): FREE, ISSUED, COMMITTED.
- Transitions:
  - FREE -> ISSUED on issue_i with matching id.
  - ISSUED -> COMMITTED on commit_valid_i & ~commit_kill_i with matching id.
  - ISSUED -> FREE on commit_valid_i & commit_kill_i with matching id.
  - COMMITTED -> FREE on retire_i with matching id.
- All updates take effect on the clock edge. The updated state is visible the next cycle.
- Same-id issue and commit in one cycle: the entry goes directly FREE -> COMMITTED, or stays FREE if killed.
- Issue of id A and retire of id B in the same cycle are independent. outstanding_o is unchanged.
- kill_o: registered; high exactly one cycle after a kill commit that hits an ISSUED entry (or a same-cycle issue). Kill of a FREE or COMMITTED entry: no pulse, state unchanged, err_o set.
- ex_commit_o: combinational = ex_valid_i & (state[ex_id_i]==COMMITTED). Because it is combinational, EX may hold and wait for it (no extra latency beyond the commit register).
- ready_o: combinational = outstanding_o < MAX_OUTSTANDING, computed from registered state. A retire in the same cycle does not raise ready early.
- outstanding_o: registered counter, +1 on issue, -1 on retire or effective kill, net change when both occur. Saturates at 0 and at 2**X_ID_WIDTH (saturation sets err_o).
- err_o is set and held until reset or clear by any of:
  - issue into a non-FREE entry (entry is overwritten to ISSUED);
  - retire of a non-COMMITTED entry (ignored);
  - commit to a FREE entry with no same-cycle issue (ignored).
- clear_i: all entries FREE, counter 0, kill_o 0, err_o 0. clear_i overrides all same-cycle events.
- Reset values: all entries FREE; ex_commit_o 0; ready_o 1; kill_o 0; outstanding_o 0; err_o 0.
- Reset mid-operation: all in-flight state is discarded and no kill_o pulse is generated.

Decomposition:
- Package fir_xifu_pkg receives:
  - sb_state_t enum (2-bit);
  - id2ctrl_t (issue, id);
  - ctrl2ex_t (commit, kill);
  - constant X_ID_WIDTH_DEFAULT.
- One sub-module, fir_xifu_sb_entry: a single entry's FSM with issue/commit/kill/retire hit inputs and state/error outputs, instantiated 2**X_ID_WIDTH times in a generate loop. The counter, kill register and error flag stay in the top level.

Test Plan:
- Reset, then issue id 3, commit id 3 (kill=0) next cycle, EX holds id 3 -> ex_commit_o=0 in the commit cycle, 1 the cycle after; retire id 3 -> entry FREE, outstanding_o=0.
- Issue ids 0..3 back-to-back, no retire (MAX_OUTSTANDING=4) -> outstanding_o=4, ready_o=0; retire id 0 after commit -> ready_o=1 on the next cycle.
- Issue id 5 and commit id 5 with kill=1 in the same cycle -> entry stays FREE, kill_o high exactly one cycle later, outstanding_o unchanged at 0.
- Issue id 2 and retire id 1 (committed) in the same cycle -> outstanding_o unchanged, both entries updated correctly.
- Retire id 7 while FREE -> err_o=1 and held; clear_i -> err_o=0, all FREE, ready_o=1.
- Issue ids 1 and 2 with id 1 committed, then assert rst_ni=0 asynchronously mid-cycle -> all outputs return to reset values immediately, no kill_o pulse after release.
